// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes and arbiter FSM state type for the ALU slice
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational ADD/SUB/AND/OR unit shared by the arbiter
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result
);

    // Wrapping arithmetic: carry and borrow are intentionally dropped.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU among NREQ requesters
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*WIDTH-1:0]     req_b,
    input  logic [NREQ*2-1:0]         req_op,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [WIDTH-1:0]          rsp_result,
    output logic                      busy
);

    localparam int IDW = $clog2(NREQ);
    // Pointer starts at the last requester so requester 0 wins first after reset.
    localparam logic [IDW-1:0] PTR_RESET = IDW'(NREQ - 1);

    arb_state_t       state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   op_id;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       op_code;
    logic [WIDTH-1:0] alu_result;
    logic             accept;

    // First valid requester after 'last', wrapping; lowest offset wins.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                               input logic [IDW-1:0]  last);
        logic [IDW-1:0] pick;
        int             idx;
        pick = last;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NREQ;
            if (valid[idx]) pick = idx[IDW-1:0];
        end
        return pick;
    endfunction

    alu #(.WIDTH(WIDTH)) u_alu (
        .a      (op_a),
        .b      (op_b),
        .op     (op_code),
        .result (alu_result)
    );

    // Grant decision: only in IDLE, never while reset is applied.
    always_comb begin
        winner    = rr_pick(req_valid, ptr);
        accept    = (state == IDLE) && (|req_valid) && !rst;
        req_ready = '0;
        if (accept) req_ready[winner] = 1'b1;
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    // Accept -> execute -> hold response until consumed; reset drops any in-flight op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= PTR_RESET;
            op_a       <= '0;
            op_b       <= '0;
            op_code    <= '0;
            op_id      <= '0;
            rsp_result <= '0;
            rsp_id     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a    <= req_a[int'(winner)*WIDTH +: WIDTH];
                        op_b    <= req_b[int'(winner)*WIDTH +: WIDTH];
                        op_code <= req_op[int'(winner)*2 +: 2];
                        op_id   <= winner;
                        ptr     <= winner;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_id     <= op_id;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for the round-robin ALU arbiter
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [7:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_result;
    logic        busy;

    typedef struct {
        int         id;
        logic [7:0] result;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    alu_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    // Monitor: every consumed response must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_rsp: got id %0d result %0d expected no response", rsp_id, rsp_result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_result", 32'(rsp_result), 32'(e.result));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle_timeout", 32'(busy), 0);
        tick();
    endtask

    task automatic load_ops();
        req_a  = {8'd40, 8'd30, 8'd20, 8'd10};
        req_b  = {8'd4, 8'd3, 8'd2, 8'd1};
        req_op = {2'b11, 2'b10, 2'b01, 2'b00};
    endtask

    task automatic single_op(input int id, input logic [7:0] a, input logic [7:0] b,
                             input logic [1:0] op, input logic [7:0] exp_r);
        bit   got;
        exp_t e;
        req_a[id*8 +: 8] = a;
        req_b[id*8 +: 8] = b;
        req_op[id*2 +: 2] = op;
        req_valid[id] = 1'b1;
        e.id = id;
        e.result = exp_r;
        sb.push_back(e);
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1;
            tick();
        end
        chk("accept", 32'(got), 1);
        req_valid[id] = 1'b0;
        @(negedge clk);
        chk("exec_no_rsp", 32'(rsp_valid), 0);
        @(negedge clk);
        chk("rsp_latency", 32'(rsp_valid), 1);
        wait_idle();
    endtask

    initial begin
        int   order [5];
        int   n;
        int   last;
        bit   got;
        exp_t e;

        order     = '{0, 1, 2, 3, 0};
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_result", 32'(rsp_result), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        tick();
        rst = 1'b0;

        // Directed single operations
        single_op(0, 8'd200, 8'd100, 2'b00, 8'd44);
        single_op(2, 8'd5, 8'd10, 2'b01, 8'd251);
        single_op(2, 8'hF0, 8'h3C, 2'b10, 8'h30);
        single_op(2, 8'hF0, 8'h3C, 2'b11, 8'hFC);

        // Reset during EXEC: pointer sits at 2, so requester 3 wins first
        load_ops();
        req_valid = 4'b1010;
        @(negedge clk);
        chk("pre_rst_grant", 32'(req_ready), 32'h8);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_exec_busy", 32'(busy), 0);
        chk("rst_exec_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_exec_req_ready", 32'(req_ready), 0);
        tick();
        rst = 1'b0;
        e.id = 1;
        e.result = 8'd18;
        sb.push_back(e);
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (req_ready != 0) begin
                got = 1;
                chk("post_rst_grant", 32'(req_ready), 32'h2);
            end
            tick();
        end
        chk("post_rst_accept", 32'(got), 1);
        req_valid = '0;
        wait_idle();

        // Fresh reset so round robin starts at requester 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        load_ops();
        foreach (order[i]) begin
            e.id = order[i];
            case (order[i])
                0: e.result = 8'd11;
                1: e.result = 8'd18;
                2: e.result = 8'd2;
                default: e.result = 8'd44;
            endcase
            sb.push_back(e);
        end
        req_valid = 4'hF;
        n = 0;
        last = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            @(negedge clk);
            if (req_ready != 0) begin
                chk("rr_onehot", 32'($countones(req_ready)), 1);
                chk("rr_order", 32'(req_ready), 32'(1) << order[n]);
                if (n > 0) chk("rr_spacing", 32'(c - last), 3);
                last = c;
                n++;
            end
            tick();
        end
        req_valid = '0;
        chk("rr_count", 32'(n), 5);
        wait_idle();

        // Backpressure: pointer at 0, requesters 1..3 valid, so 1 wins
        rsp_ready = 1'b0;
        e.id = 1;
        e.result = 8'd18;
        sb.push_back(e);
        req_valid = 4'b1110;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
        end
        chk("bp_rsp_seen", 32'(got), 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 1);
            chk("bp_rsp_result", 32'(rsp_result), 18);
            chk("bp_rsp_id", 32'(rsp_id), 1);
            chk("bp_req_ready", 32'(req_ready), 0);
            @(negedge clk);
        end
        tick();
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle();

        tick();
        tick();
        chk("sb_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one `alu` instance (8-bit ADD/SUB/AND/OR, combinational) among NREQ independent requesters. It accepts one operation at a time through per-requester valid/ready handshakes, using round-robin arbitration. It registers the operands, evaluates them on the shared `alu`, and returns the registered result with the winning requester's id through a single valid/ready response port. It sits between command sources and the ALU datapath.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, operand/result width; must equal `alu` width
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NREQ  requester i has an operation pending
- req_ready  output  NREQ  one-hot grant/accept; bit i high for exactly the accept cycle
- req_a  input  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- req_b  input  NREQ*WIDTH  operand B, same packing
- req_op  input  NREQ*2  opcode, requester i at [i*2 +: 2]; 00 ADD, 01 SUB, 10 AND, 11 OR
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  $clog2(NREQ)  index of requester that issued the result
- rsp_result  output  WIDTH  registered ALU result
- busy  output  1  high in EXEC and RESP

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE behaviour:
  - If any req_valid is high, the winner is the first set bit searching from (ptr+1) mod NREQ upward, with wrap.
  - req_ready[winner]=1 combinationally in this cycle.
  - At the edge: latch a/b/op/id of the winner into operand registers, set ptr=winner, go to EXEC.
  - No req_valid: stay in IDLE, req_ready=0.
- EXEC behaviour:
  - Operand registers drive the `alu`.
  - At the edge: capture `alu` result into rsp_result and id into rsp_id, go to RESP.
- RESP behaviour:
  - rsp_valid=1; rsp_result and rsp_id held stable.
  - rsp_ready=1 completes the handshake: go to IDLE.
  - Otherwise stay in RESP.
- req_ready is always 0 outside IDLE. There is no overlap and no bypass.
- Requesters hold req_a/req_b/req_op stable while req_valid is high and not yet granted. A requester may drop req_valid before its grant; it is then simply not selected.
- Arithmetic is modulo 2^WIDTH: ADD and SUB wrap, and no carry or borrow is reported. AND and OR are bitwise.
- Fairness: a continuously requesting requester waits at most NREQ-1 other operations.

## Timing
- Reset values:
  - state=IDLE
  - ptr=NREQ-1, so requester 0 has first priority after reset
  - rsp_valid=0, rsp_result=0, rsp_id=0, busy=0, req_ready=0
  - operand registers=0
- Latency: accept at edge t → rsp_valid high in cycle t+2 when the consumer is ready.
- Throughput: one operation per 3 cycles maximum (IDLE, EXEC, RESP). The IDLE cycle after a response is mandatory.
- Simultaneous events:
  - rsp_ready in the first RESP cycle: response consumed; the next grant occurs in the following IDLE cycle.
  - All requesters valid: grants rotate 0,1,2,…,NREQ-1,0.
- Backpressure: rsp_ready low holds RESP indefinitely, with outputs frozen and no grants.
- Reset in any state: the in-flight operation is discarded without a response, and all registers return to their reset values on that edge.

## Structure
- Shared package `alu_pkg` holds:
  - opcode localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11
  - the FSM state enum (IDLE, EXEC, RESP)
- Sub-module: the existing `alu` (a, b, op → result), instantiated once, unmodified.
- The round-robin priority search is a combinational function inside alu_arbiter. It is not a separate module.

## Test plan
- Single requester 0, a=200, b=100, ADD → rsp_result=44 (wrap), rsp_id=0, rsp_valid in the second cycle after accept.
- Requester 2, a=5, b=10, SUB → rsp_result=251; separately a=8'hF0, b=8'h3C AND → 8'h30; OR → 8'hFC.
- All 4 requesters valid continuously, rsp_ready=1 → grant order 0,1,2,3,0, with exactly one req_ready bit per accept and 3 cycles between accepts.
- Backpressure: rsp_ready held low for 5 cycles while other requesters are valid → rsp_valid, rsp_result and rsp_id stable, req_ready=0 throughout; resumes after rsp_ready=1.
- rst asserted during EXEC → next cycle state IDLE, rsp_valid=0, no response for the discarded op; the first subsequent grant goes to the lowest-index valid requester.
